// File: rtl/dmem_trace_monitor_if.sv
// ----------------------------------------------------------------------------
// dmem_trace_monitor_if
//
// Purpose: bundles the core store bus that the tracer observes and the
// valid/ready read port through which captured stores are drained.
//
// Signals:
//   memwrite, address, write_data : store strobe/address/data from the core
//   rd_ready                      : consumer accepts the head entry
//   rd_valid, rd_addr, rd_data,
//   rd_stamp                      : head entry of the trace FIFO
//   count                         : entries currently held
//   dropped, overflow             : lost-store counter (saturating) / sticky flag
//   done, pass                    : tohost store seen / test verdict
//
// Modports:
//   master : core/consumer side (drives store bus and rd_ready)
//   slave  : the trace monitor
// ----------------------------------------------------------------------------
interface dmem_trace_monitor_if #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            memwrite;
  logic [XLEN-1:0] address;
  logic [XLEN-1:0] write_data;
  logic            rd_ready;
  logic            rd_valid;
  logic [XLEN-1:0] rd_addr;
  logic [XLEN-1:0] rd_data;
  logic [31:0]     rd_stamp;
  logic [CW-1:0]   count;
  logic [15:0]     dropped;
  logic            overflow;
  logic            done;
  logic            pass;

  modport master (
    output memwrite, address, write_data, rd_ready,
    input  rd_valid, rd_addr, rd_data, rd_stamp, count, dropped, overflow,
           done, pass
  );

  modport slave (
    input  memwrite, address, write_data, rd_ready,
    output rd_valid, rd_addr, rd_data, rd_stamp, count, dropped, overflow,
           done, pass
  );
endinterface

// File: rtl/dmem_trace_monitor.sv
// ----------------------------------------------------------------------------
// dmem_trace_monitor
//
// Purpose: hardware trace of data-memory stores. Every store seen on the core
// store bus is pushed into a DEPTH-entry FIFO together with a cycle stamp and
// can be drained through a valid/ready read port. A store to TOHOST_ADDR ends
// the test: done/pass are latched and capture stops until reset.
//
// Ports:
//   clk    : clock, all logic on rising edge
//   reset  : synchronous, active-low reset
//   bus    : dmem_trace_monitor_if.slave (store bus in, read port/status out)
//
// Parameters:
//   XLEN        : address/data width
//   DEPTH       : FIFO entries, power of two, >= 2
//   WRAP_MODE   : 0 = discard new store when full, 1 = overwrite oldest entry
//   TOHOST_ADDR : end-of-test store address (low XLEN bits used)
//
// Configuration macro:
//   DMEM_TRACE_STAMP_EN : builds the 32-bit cycle counter and per-entry stamp
//                         storage; when undefined rd_stamp is tied to zero.
// ----------------------------------------------------------------------------
module dmem_trace_monitor #(
  parameter int          XLEN        = 64,
  parameter int          DEPTH       = 16,
  parameter int          WRAP_MODE   = 0,
  parameter logic [63:0] TOHOST_ADDR = 64'h0000_0000_0000_1000
) (
  input logic                clk,
  input logic                reset,
  dmem_trace_monitor_if.slave bus
);

  localparam int              AW       = $clog2(DEPTH);
  localparam int              CW       = AW + 1;
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
  localparam logic [XLEN-1:0] TOHOST   = XLEN'(TOHOST_ADDR);
  localparam bit              WRAP     = (WRAP_MODE != 0);

  typedef enum logic {CAPTURE, HALTED} state_e;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } entry_t;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [15:0]     dropped_q, dropped_d;
  logic            overflow_q, overflow_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;

  entry_t          mem_q [DEPTH];

  logic            rd_valid;
  logic            pop;
  logic            store_req;
  logic            full;
  logic            write_en;
  logic            lost;
  logic            evict;
  logic            tohost_hit;

  // --------------------------------------------------------------------------
  // Capture/halt FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    store_req  = 1'b0;
    tohost_hit = 1'b0;
    case (state_q)
      CAPTURE: begin
        store_req  = bus.memwrite;
        tohost_hit = bus.memwrite && (bus.address == TOHOST);
        if (tohost_hit) state_d = HALTED;
      end
      HALTED: begin
        // Stores are ignored here and are not counted as lost.
        state_d = HALTED;
      end
      default: state_d = CAPTURE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FIFO control
  // --------------------------------------------------------------------------
  always_comb begin
    rd_valid   = (count_q != '0);
    pop        = rd_valid && bus.rd_ready;
    full       = (count_q == FULL_CNT);
    // A full FIFO still accepts a store when the head leaves in the same
    // cycle, or when wrapping is enabled (the head is evicted instead).
    write_en   = store_req && (!full || pop || WRAP);
    lost       = store_req && full && !pop;
    evict      = lost && WRAP;

    wr_ptr_d   = wr_ptr_q + (write_en ? AW'(1) : AW'(0));
    rd_ptr_d   = rd_ptr_q + ((pop || evict) ? AW'(1) : AW'(0));

    count_d    = count_q;
    if (write_en && !(pop || evict))      count_d = count_q + CW'(1);
    else if (!write_en && pop)            count_d = count_q - CW'(1);

    dropped_d  = dropped_q;
    if (lost && (dropped_q != 16'hFFFF))  dropped_d = dropped_q + 16'd1;
    overflow_d = overflow_q | lost;

    done_d     = done_q | tohost_hit;
    pass_d     = tohost_hit ? (bus.write_data == XLEN'(1)) : pass_q;
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of block order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= CAPTURE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      dropped_q  <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      dropped_q  <= dropped_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  // NOTE: the entry storage is deliberately not reset; contents are only
  // observable through rd_valid, which derives from the reset count.
  always_ff @(posedge clk) begin
    if (reset && write_en) mem_q[wr_ptr_q] <= '{addr: bus.address, data: bus.write_data};
  end

  // --------------------------------------------------------------------------
  // Optional cycle stamp
  // --------------------------------------------------------------------------
`ifdef DMEM_TRACE_STAMP_EN
  logic [31:0] stamp_q;
  logic [31:0] stamp_mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset) stamp_q <= '0;
    else        stamp_q <= stamp_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset && write_en) stamp_mem_q[wr_ptr_q] <= stamp_q;
  end

  assign bus.rd_stamp = rd_valid ? stamp_mem_q[rd_ptr_q] : 32'h0;
`else
  assign bus.rd_stamp = 32'h0;
`endif

  // Head fields read zero while the FIFO is empty so that reset leaves
  // every output at zero.
  assign bus.rd_valid = rd_valid;
  assign bus.rd_addr  = rd_valid ? mem_q[rd_ptr_q].addr : '0;
  assign bus.rd_data  = rd_valid ? mem_q[rd_ptr_q].data : '0;
  assign bus.count    = count_q;
  assign bus.dropped  = dropped_q;
  assign bus.overflow = overflow_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;

endmodule

// File: tb/tb_dmem_trace_monitor.sv
// ----------------------------------------------------------------------------
// tb_dmem_trace_monitor
//
// Drives two DEPTH=4 monitors (WRAP_MODE 0 and 1) with the same store/read
// stimulus and compares both against a queue-based reference model.
// ----------------------------------------------------------------------------
module tb_dmem_trace_monitor;

  localparam int          XLEN   = 64;
  localparam int          DEPTH  = 4;
  localparam int          CW     = $clog2(DEPTH) + 1;
  localparam logic [63:0] TOHOST = 64'h0000_0000_0000_1000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0;
  logic [63:0] address = '0;
  logic [63:0] write_data = '0;
  logic        rd_ready = 1'b0;

  always #5 clk = ~clk;

  dmem_trace_monitor_if #(.XLEN(XLEN), .DEPTH(DEPTH)) if0 ();
  dmem_trace_monitor_if #(.XLEN(XLEN), .DEPTH(DEPTH)) if1 ();

  assign if0.memwrite = memwrite;   assign if1.memwrite = memwrite;
  assign if0.address = address;     assign if1.address = address;
  assign if0.write_data = write_data; assign if1.write_data = write_data;
  assign if0.rd_ready = rd_ready;   assign if1.rd_ready = rd_ready;

  dmem_trace_monitor #(.XLEN(XLEN), .DEPTH(DEPTH), .WRAP_MODE(0), .TOHOST_ADDR(TOHOST))
    u_dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  dmem_trace_monitor #(.XLEN(XLEN), .DEPTH(DEPTH), .WRAP_MODE(1), .TOHOST_ADDR(TOHOST))
    u_dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

  // Outputs of both monitors gathered into arrays indexed by monitor.
  logic          o_valid [2];
  logic [63:0]   o_addr  [2];
  logic [63:0]   o_data  [2];
  logic [31:0]   o_stamp [2];
  logic [CW-1:0] o_count [2];
  logic [15:0]   o_drop  [2];
  logic          o_ovf   [2];
  logic          o_done  [2];
  logic          o_pass  [2];

  assign o_valid[0] = if0.rd_valid; assign o_valid[1] = if1.rd_valid;
  assign o_addr[0]  = if0.rd_addr;  assign o_addr[1]  = if1.rd_addr;
  assign o_data[0]  = if0.rd_data;  assign o_data[1]  = if1.rd_data;
  assign o_stamp[0] = if0.rd_stamp; assign o_stamp[1] = if1.rd_stamp;
  assign o_count[0] = if0.count;    assign o_count[1] = if1.count;
  assign o_drop[0]  = if0.dropped;  assign o_drop[1]  = if1.dropped;
  assign o_ovf[0]   = if0.overflow; assign o_ovf[1]   = if1.overflow;
  assign o_done[0]  = if0.done;     assign o_done[1]  = if1.done;
  assign o_pass[0]  = if0.pass;     assign o_pass[1]  = if1.pass;

  // --------------------------------------------------------------------------
  // Reference model: one queue per monitor, index 1 overwrites when full.
  // --------------------------------------------------------------------------
  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    int unsigned stamp;
  } ent_t;

  ent_t        mq [2][$];
  int          m_drop [2];
  bit          m_ovf  [2];
  bit          m_done [2];
  bit          m_pass [2];
  bit          m_halt [2];
  int unsigned cyc;

  int tests = 0;
  int fails = 0;

  function automatic void model_edge();
    ent_t e;
    bit   pop_m;
    bit   push_m;
    if (!reset) begin
      for (int m = 0; m < 2; m++) begin
        mq[m].delete();
        m_drop[m] = 0; m_ovf[m] = 0; m_done[m] = 0; m_pass[m] = 0; m_halt[m] = 0;
      end
      cyc = 0;
      return;
    end
    for (int m = 0; m < 2; m++) begin
      pop_m  = (mq[m].size() > 0) && rd_ready;
      push_m = memwrite && !m_halt[m];
      if (pop_m) void'(mq[m].pop_front());
      if (push_m) begin
        e.addr = address; e.data = write_data; e.stamp = cyc;
        if (mq[m].size() < DEPTH) begin
          mq[m].push_back(e);
        end else begin
          if (m == 1) begin
            void'(mq[m].pop_front());
            mq[m].push_back(e);
          end
          if (m_drop[m] < 65535) m_drop[m]++;
          m_ovf[m] = 1;
        end
        if (address == TOHOST) begin
          m_done[m] = 1;
          m_pass[m] = (write_data == 64'd1);
          m_halt[m] = 1;
        end
      end
    end
    cyc++;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic mw, input logic [63:0] a, input logic [63:0] d,
                       input logic rdy);
    memwrite = mw; address = a; write_data = d; rd_ready = rdy;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b0; memwrite = 1'b0; rd_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b0; memwrite = 1'b1; address = 64'h20; write_data = 64'h5; rd_ready = 1'b1;
    tick();
    tick();
    for (int m = 0; m < 2; m++) begin
      tests++;
      if (o_valid[m] !== 1'b0 || o_addr[m] !== '0 || o_data[m] !== '0 ||
          o_stamp[m] !== '0 || o_count[m] !== '0 || o_drop[m] !== '0 ||
          o_ovf[m] !== 1'b0 || o_done[m] !== 1'b0 || o_pass[m] !== 1'b0) begin
        fails++;
        $display("FAIL reset_outputs dut%0d: valid=%b addr=%0h data=%0h stamp=%0h count=%0d dropped=%0d ovf=%b done=%b pass=%b, required all 0",
                 m, o_valid[m], o_addr[m], o_data[m], o_stamp[m], o_count[m], o_drop[m],
                 o_ovf[m], o_done[m], o_pass[m]);
      end
    end
    reset = 1'b1;
    drive(1'b1, 64'h20, 64'h5, 1'b0);
    for (int m = 0; m < 2; m++) begin
      tests++;
      if (o_valid[m] !== 1'b1 || o_addr[m] !== 64'h20 || o_data[m] !== 64'h5) begin
        fails++;
        $display("FAIL first_store dut%0d: valid=%b addr=%0h data=%0h, required 1/20/5",
                 m, o_valid[m], o_addr[m], o_data[m]);
      end
      tests++;
      if (o_count[m] !== CW'(1)) begin
        fails++;
        $display("FAIL first_count dut%0d: got %0d required 1", m, o_count[m]);
      end
    end
  endtask

  task automatic test_full_modes();
    logic [63:0] exp_d;
    do_reset();
    for (int i = 1; i <= 5; i++) drive(1'b1, 64'h100 + 64'(8 * i), 64'(i), 1'b0);
    for (int m = 0; m < 2; m++) begin
      tests++;
      if (o_count[m] !== CW'(4) || o_drop[m] !== 16'd1 || o_ovf[m] !== 1'b1) begin
        fails++;
        $display("FAIL full_status dut%0d: count=%0d dropped=%0d ovf=%b, required 4/1/1",
                 m, o_count[m], o_drop[m], o_ovf[m]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      for (int m = 0; m < 2; m++) begin
        exp_d = (m == 0) ? 64'(k + 1) : 64'(k + 2);
        tests++;
        if (o_valid[m] !== 1'b1 || o_data[m] !== exp_d) begin
          fails++;
          $display("FAIL full_read%0d dut%0d: valid=%b data=%0h required 1/%0h",
                   k, m, o_valid[m], o_data[m], exp_d);
        end
      end
      drive(1'b0, '0, '0, 1'b1);
    end
    for (int m = 0; m < 2; m++) begin
      tests++;
      if (o_valid[m] !== 1'b0 || o_drop[m] !== 16'd1) begin
        fails++;
        $display("FAIL full_drained dut%0d: valid=%b dropped=%0d required 0/1",
                 m, o_valid[m], o_drop[m]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 1; i <= 4; i++) drive(1'b1, 64'h400 + 64'(8 * i), 64'(i), 1'b0);
    for (int k = 0; k < 10; k++) begin
      for (int m = 0; m < 2; m++) begin
        tests++;
        if (o_valid[m] !== 1'b1 || o_data[m] !== 64'(k + 1)) begin
          fails++;
          $display("FAIL b2b_head%0d dut%0d: valid=%b data=%0h required 1/%0h",
                   k, m, o_valid[m], o_data[m], k + 1);
        end
      end
      if (k < 6) begin
        drive(1'b1, 64'h500 + 64'(8 * k), 64'(k + 5), 1'b1);
        for (int m = 0; m < 2; m++) begin
          tests++;
          if (o_count[m] !== CW'(4) || o_drop[m] !== 16'd0 || o_ovf[m] !== 1'b0) begin
            fails++;
            $display("FAIL b2b_status%0d dut%0d: count=%0d dropped=%0d ovf=%b required 4/0/0",
                     k, m, o_count[m], o_drop[m], o_ovf[m]);
          end
        end
      end else begin
        drive(1'b0, '0, '0, 1'b1);
      end
    end
  endtask

  task automatic test_tohost(input logic [63:0] val, input logic exp_pass);
    do_reset();
    drive(1'b1, 64'h300, 64'hA, 1'b0);
    drive(1'b1, 64'h308, 64'hB, 1'b0);
    for (int m = 0; m < 2; m++) begin
      tests++;
      if (o_done[m] !== 1'b0) begin
        fails++;
        $display("FAIL tohost_early_done dut%0d: got %b required 0", m, o_done[m]);
      end
    end
    drive(1'b1, TOHOST, val, 1'b0);
    for (int m = 0; m < 2; m++) begin
      tests++;
      if (o_done[m] !== 1'b1 || o_pass[m] !== exp_pass || o_count[m] !== CW'(3)) begin
        fails++;
        $display("FAIL tohost_seen dut%0d: done=%b pass=%b count=%0d required 1/%b/3",
                 m, o_done[m], o_pass[m], o_count[m], exp_pass);
      end
    end
    drive(1'b1, 64'h310, 64'hC, 1'b0);
    for (int m = 0; m < 2; m++) begin
      tests++;
      if (o_count[m] !== CW'(3) || o_drop[m] !== 16'd0 || o_done[m] !== 1'b1 ||
          o_pass[m] !== exp_pass) begin
        fails++;
        $display("FAIL tohost_halted dut%0d: count=%0d dropped=%0d done=%b pass=%b required 3/0/1/%b",
                 m, o_count[m], o_drop[m], o_done[m], o_pass[m], exp_pass);
      end
    end
    drive(1'b0, '0, '0, 1'b1);
    drive(1'b0, '0, '0, 1'b1);
    for (int m = 0; m < 2; m++) begin
      tests++;
      if (o_valid[m] !== 1'b1 || o_addr[m] !== TOHOST || o_data[m] !== val) begin
        fails++;
        $display("FAIL tohost_last dut%0d: valid=%b addr=%0h data=%0h required 1/%0h/%0h",
                 m, o_valid[m], o_addr[m], o_data[m], TOHOST, val);
      end
    end
    drive(1'b0, '0, '0, 1'b1);
    for (int m = 0; m < 2; m++) begin
      tests++;
      if (o_valid[m] !== 1'b0) begin
        fails++;
        $display("FAIL tohost_drained dut%0d: valid=%b required 0", m, o_valid[m]);
      end
    end
  endtask

  task automatic test_stamp();
    logic [31:0] exp5;
    logic [31:0] exp9;
`ifdef DMEM_TRACE_STAMP_EN
    exp5 = 32'd5; exp9 = 32'd9;
`else
    exp5 = 32'd0; exp9 = 32'd0;
`endif
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b0, '0, '0, 1'b0);
    drive(1'b1, 64'h40, 64'h1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, '0, '0, 1'b0);
    drive(1'b1, 64'h48, 64'h2, 1'b0);
    for (int m = 0; m < 2; m++) begin
      tests++;
      if (o_stamp[m] !== exp5) begin
        fails++;
        $display("FAIL stamp_first dut%0d: got %0d required %0d", m, o_stamp[m], exp5);
      end
    end
    drive(1'b0, '0, '0, 1'b1);
    for (int m = 0; m < 2; m++) begin
      tests++;
      if (o_stamp[m] !== exp9) begin
        fails++;
        $display("FAIL stamp_second dut%0d: got %0d required %0d", m, o_stamp[m], exp9);
      end
    end
  endtask

  task automatic test_random(input int n);
    logic [31:0] exp_s;
    do_reset();
    for (int i = 0; i < n; i++) begin
      reset      = ($urandom_range(0, 149) != 0);
      memwrite   = ($urandom_range(0, 2) != 0);
      address    = ($urandom_range(0, 59) == 0) ? TOHOST
                                                : {$urandom, $urandom & 32'hFFFF_EFF8};
      write_data = ($urandom_range(0, 3) == 0) ? 64'(($urandom_range(0, 2)))
                                               : {$urandom, $urandom};
      rd_ready   = $urandom_range(0, 1) == 1;
      tick();
      for (int m = 0; m < 2; m++) begin
        tests++;
        if (o_valid[m] !== (mq[m].size() > 0) || o_count[m] !== CW'(mq[m].size())) begin
          fails++;
          $display("FAIL rnd_level cyc%0d dut%0d: valid=%b count=%0d required %b/%0d",
                   i, m, o_valid[m], o_count[m], mq[m].size() > 0, mq[m].size());
        end
        tests++;
        if (o_drop[m] !== 16'(m_drop[m]) || o_ovf[m] !== m_ovf[m] ||
            o_done[m] !== m_done[m] || o_pass[m] !== m_pass[m]) begin
          fails++;
          $display("FAIL rnd_status cyc%0d dut%0d: dropped=%0d ovf=%b done=%b pass=%b required %0d/%b/%b/%b",
                   i, m, o_drop[m], o_ovf[m], o_done[m], o_pass[m],
                   m_drop[m], m_ovf[m], m_done[m], m_pass[m]);
        end
        if (mq[m].size() > 0) begin
`ifdef DMEM_TRACE_STAMP_EN
          exp_s = mq[m][0].stamp;
`else
          exp_s = 32'd0;
`endif
          tests++;
          if (o_addr[m] !== mq[m][0].addr || o_data[m] !== mq[m][0].data ||
              o_stamp[m] !== exp_s) begin
            fails++;
            $display("FAIL rnd_head cyc%0d dut%0d: addr=%0h data=%0h stamp=%0d required %0h/%0h/%0d",
                     i, m, o_addr[m], o_data[m], o_stamp[m],
                     mq[m][0].addr, mq[m][0].data, exp_s);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_modes();
    test_back_to_back();
    test_tohost(64'd1, 1'b1);
    test_tohost(64'd3, 1'b0);
    test_stamp();
    test_random(1500);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
